// File: rtl/instruction_encoder.sv
// ---------------------------------------------------------------------------
// instruction_encoder
//
// Packs RISC-V style instruction fields (R, I and S formats) into 32-bit
// words and hands them to an instruction memory together with a word address.
// One output register stage; a single address counter fills the memory from
// address 0 up to DEPTH-1, after which input is refused until flush or reset.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both 1. The producer holds its data stable while valid=1 and ready=0;
// the consumer may change ready freely. The same rule applies on the input
// side (in_valid/in_ready) and the output side (out_valid/out_ready).
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   flush             synchronous clear of output stage, counter, full, illegal
//   in_valid/in_ready input handshake for one field set
//   opcode, rd, rs1, rs2, funct3, funct7, imm   instruction fields
//   out_valid/out_ready output handshake towards instruction memory
//   instr, out_addr   encoded word and its word address
//   mem_full          DEPTH words accepted; input blocked
//   illegal           sticky: an unsupported opcode was accepted
//   fsm_state         debug view of the output-stage state (0 EMPTY, 1 HOLD)
// ---------------------------------------------------------------------------
module instruction_encoder #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        opcode,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [11:0]       imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       instr,
    output logic [ADDR_W-1:0] out_addr,
    output logic              mem_full,
    output logic              illegal,
    output logic [0:0]        fsm_state
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [31:0]       NOP_WORD  = 32'h0000_0013;
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    logic [0:0]        state;
    logic [0:0]        state_next;
    logic [ADDR_W-1:0] addr_cnt;
    logic              in_hs;
    logic              out_hs;
    logic [31:0]       enc_word;
    logic              enc_illegal;

    assign out_valid = (state == ST_HOLD);
    assign fsm_state = state;

    // rst_n is included so the encoder never advertises ready while it is
    // being held in reset.
    assign in_ready = rst_n && (!out_valid || out_ready) && !mem_full && !flush;
    assign in_hs    = in_valid && in_ready;
    assign out_hs   = out_valid && out_ready;

    // Field packing. Fields that a format does not use are simply dropped.
    always_comb begin
        enc_word    = NOP_WORD;
        enc_illegal = 1'b0;
        case (opcode)
            OP_R:              enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
            OP_LOAD, OP_IMM:   enc_word = {imm, rs1, funct3, rd, opcode};
            OP_STORE:          enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            default: begin
                enc_word    = NOP_WORD;
                enc_illegal = 1'b1;
            end
        endcase
    end

    // Output stage: a new word always wins over draining, so a cycle with
    // both handshakes stays in HOLD and the register is simply overwritten.
    always_comb begin
        state_next = state;
        case (state)
            ST_EMPTY: if (in_hs) state_next = ST_HOLD;
            ST_HOLD:  if (out_hs && !in_hs) state_next = ST_EMPTY;
            default:  state_next = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_EMPTY;
            instr    <= '0;
            out_addr <= '0;
            addr_cnt <= '0;
            mem_full <= 1'b0;
            illegal  <= 1'b0;
        end else if (flush) begin
            state    <= ST_EMPTY;
            instr    <= '0;
            out_addr <= '0;
            addr_cnt <= '0;
            mem_full <= 1'b0;
            illegal  <= 1'b0;
        end else begin
            state <= state_next;
            if (in_hs) begin
                instr    <= enc_word;
                out_addr <= addr_cnt;
                // Counter wraps to 0 naturally; mem_full is what stops reuse.
                addr_cnt <= addr_cnt + 1'b1;
                if (addr_cnt == ADDR_LAST) begin
                    mem_full <= 1'b1;
                end
                if (enc_illegal) begin
                    illegal <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instruction_encoder.sv
module tb_instruction_encoder;

    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [6:0]    opcode;
    logic [4:0]    rd;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [2:0]    funct3;
    logic [6:0]    funct7;
    logic [11:0]   imm;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   instr;
    logic [AW-1:0] out_addr;
    logic          mem_full;
    logic          illegal;
    logic [0:0]    fsm_state;

    instruction_encoder #(.ADDR_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opcode    (opcode),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .funct3    (funct3),
        .funct7    (funct7),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .instr     (instr),
        .out_addr  (out_addr),
        .mem_full  (mem_full),
        .illegal   (illegal),
        .fsm_state (fsm_state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- counters ----------------
    int checks = 0;
    int passes = 0;
    int fails  = 0;

    // ---------------- reference model ----------------
    // Tracks how many words have been accepted since the last clear; the
    // address of a word is that count modulo DEPTH and the memory is full
    // once the count reaches DEPTH.
    logic        m_valid;
    logic [31:0] m_instr;
    int          m_addr;
    int          m_cnt;
    logic        m_ill;

    function automatic logic ref_legal(input int unsigned op);
        return (op == 51) || (op == 3) || (op == 19) || (op == 35);
    endfunction

    function automatic logic [31:0] ref_enc(input int unsigned op, input int unsigned f_rd,
                                            input int unsigned f_rs1, input int unsigned f_rs2,
                                            input int unsigned f3, input int unsigned f7,
                                            input int unsigned f_imm);
        int unsigned w;
        if (op == 51)
            w = f7 * (2**25) + f_rs2 * (2**20) + f_rs1 * (2**15) + f3 * (2**12) + f_rd * (2**7) + op;
        else if (op == 3 || op == 19)
            w = f_imm * (2**20) + f_rs1 * (2**15) + f3 * (2**12) + f_rd * (2**7) + op;
        else if (op == 35)
            w = (f_imm / 32) * (2**25) + f_rs2 * (2**20) + f_rs1 * (2**15) + f3 * (2**12)
                + (f_imm % 32) * (2**7) + op;
        else
            w = 19;
        return 32'(w);
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_instr = 32'h0;
        m_addr  = 0;
        m_cnt   = 0;
        m_ill   = 1'b0;
    endtask

    // ---------------- check ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic set_fields(input int unsigned op, input int unsigned f_rd, input int unsigned f_rs1,
                              input int unsigned f_rs2, input int unsigned f3, input int unsigned f7,
                              input int unsigned f_imm);
        opcode = 7'(op);
        rd     = 5'(f_rd);
        rs1    = 5'(f_rs1);
        rs2    = 5'(f_rs2);
        funct3 = 3'(f3);
        funct7 = 7'(f7);
        imm    = 12'(f_imm);
    endtask

    // Inputs are already applied (just after a rising edge). Compare at the
    // falling edge, advance the model, then move to just after the next edge.
    task automatic step();
        logic exp_ir;
        logic ihs;
        @(negedge clk);
        exp_ir = (!m_valid || out_ready) && (m_cnt < DEPTH) && !flush;
        check("in_ready", 32'(in_ready), 32'(exp_ir));
        check("out_valid", 32'(out_valid), 32'(m_valid));
        check("mem_full", 32'(mem_full), 32'(m_cnt >= DEPTH));
        check("illegal", 32'(illegal), 32'(m_ill));
        if (m_valid) begin
            check("instr", instr, m_instr);
            check("out_addr", 32'(out_addr), 32'(m_addr));
        end
        ihs = in_valid && exp_ir;
        if (flush) begin
            model_reset();
        end else if (ihs) begin
            m_instr = ref_enc(opcode, rd, rs1, rs2, funct3, funct7, imm);
            m_addr  = m_cnt % DEPTH;
            m_cnt   = m_cnt + 1;
            m_valid = 1'b1;
            if (!ref_legal(opcode)) m_ill = 1'b1;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        set_fields(0, 0, 0, 0, 0, 0, 0);
        model_reset();

        // Reset state
        #12;
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_in_ready", 32'(in_ready), 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_out_addr", 32'(out_addr), 32'h0);
        check("rst_mem_full", 32'(mem_full), 32'h0);
        check("rst_illegal", 32'(illegal), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'h1);

        // R, S, I encodings
        in_valid = 1'b1; out_ready = 1'b1;
        set_fields(51, 3, 1, 2, 0, 0, 0);
        step();
        check("r_instr", instr, 32'h002081B3);
        check("r_addr", 32'(out_addr), 32'h0);
        set_fields(35, 0, 1, 2, 2, 0, 8);
        step();
        check("s_instr", instr, 32'h0020A423);
        check("s_addr", 32'(out_addr), 32'h1);
        set_fields(19, 5, 0, 0, 0, 0, 12'hFFF);
        step();
        check("i_instr", instr, 32'hFFF00293);

        // Backpressure: held word stays stable, input is refused
        out_ready = 1'b0;
        set_fields(51, 7, 8, 9, 1, 32, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_in_ready", 32'(in_ready), 32'h0);
            check("bp_instr", instr, 32'hFFF00293);
            check("bp_addr", 32'(out_addr), 32'h2);
        end
        out_ready = 1'b1;
        step();
        check("bp_next_instr", instr, ref_enc(51, 7, 8, 9, 1, 32, 0));
        check("bp_next_addr", 32'(out_addr), 32'h3);
        check("last_word_full", 32'(mem_full), 32'h1);
        check("last_word_valid", 32'(out_valid), 32'h1);
        check("full_in_ready", 32'(in_ready), 32'h0);
        in_valid = 1'b0;
        step();
        flush = 1'b1; in_valid = 1'b1;
        step();
        flush = 1'b0;

        // Illegal opcode
        set_fields(127, 1, 2, 3, 4, 5, 6);
        step();
        check("ill_instr", instr, 32'h00000013);
        check("ill_flag", 32'(illegal), 32'h1);
        set_fields(3, 4, 5, 0, 2, 0, 100);
        step();
        check("ill_sticky", 32'(illegal), 32'h1);
        check("ill_addr_inc", 32'(out_addr), 32'h1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_illegal", 32'(illegal), 32'h0);

        // Fill the memory, then flush and restart at address 0
        for (int i = 0; i < DEPTH; i++) begin
            set_fields(19, i, i + 1, 0, 0, 0, i * 3);
            step();
            check("fill_addr", 32'(out_addr), 32'(i));
        end
        check("fill_full", 32'(mem_full), 32'h1);
        check("fill_in_ready", 32'(in_ready), 32'h0);
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush_full", 32'(mem_full), 32'h0);
        step();
        check("refill_addr", 32'(out_addr), 32'h0);
        check("refill_valid", 32'(out_valid), 32'h1);

        // Reset while a word is stalled
        out_ready = 1'b0; in_valid = 1'b1;
        set_fields(35, 0, 3, 4, 1, 0, 33);
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'h0);
        check("midrst_in_ready", 32'(in_ready), 32'h0);
        check("midrst_addr", 32'(out_addr), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1; in_valid = 1'b1;
        set_fields(51, 1, 1, 1, 1, 1, 0);
        step();
        check("after_rst_addr", 32'(out_addr), 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            int unsigned pick;
            int unsigned op;
            pick = $urandom_range(0, 5);
            case (pick)
                0: op = 51;
                1: op = 3;
                2: op = 19;
                3: op = 35;
                default: op = $urandom_range(0, 127);
            endcase
            set_fields(op, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                       $urandom_range(0, 7), $urandom_range(0, 127), $urandom_range(0, 4095));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            if (m_cnt >= DEPTH) flush = ($urandom_range(0, 3) == 0);
            else                flush = ($urandom_range(0, 40) == 0);
            step();
        end
        flush = 1'b0; in_valid = 1'b0;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/instruction_encoder.md
INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

Interface
REQ-001 Parameter ADDR_W, default 6, sets the instruction-memory write-address width; DEPTH = 2^ADDR_W.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 flush  input  1  synchronous clear of output stage, address counter, full and error state.
REQ-005 in_valid  input  1  field set on inputs is valid.
REQ-006 in_ready  output  1  encoder accepts field set this cycle.
REQ-007 opcode  input  7  instruction opcode.
REQ-008 rd, rs1, rs2  input  5 each  register fields.
REQ-009 funct3  input  3; funct7  input  7  function fields.
REQ-010 imm  input  12  immediate for I and S formats.
REQ-011 out_valid  output  1  instr/out_addr hold a word for instruction memory.
REQ-012 out_ready  input  1  instruction memory accepts word this cycle.
REQ-013 instr  output  32  encoded instruction word.
REQ-014 out_addr  output  ADDR_W  word address paired with instr.
REQ-015 mem_full  output  1  DEPTH words written; no further input accepted.
REQ-016 illegal  output  1  sticky; an unsupported opcode was received.

Function
REQ-017 Input handshake = in_valid && in_ready; output handshake = out_valid && out_ready.
REQ-018 in_ready SHALL be (!out_valid || out_ready) && !mem_full && !flush.
REQ-019 R format (opcode 0110011) SHALL encode {funct7, rs2, rs1, funct3, rd, opcode}.
REQ-020 I format (opcode 0000011 or 0010011) SHALL encode {imm[11:0], rs1, funct3, rd, opcode}; rs2 and funct7 ignored.
REQ-021 S format (opcode 0100011) SHALL encode {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}; rd and funct7 ignored.
REQ-022 Any other opcode SHALL be accepted, encoded as NOP 0x00000013, and set illegal on the following edge.
REQ-023 Latency SHALL be one cycle: a word accepted at edge N is presented with out_valid=1 after edge N.
REQ-024 instr and out_addr SHALL remain stable while out_valid=1 and out_ready=0.
REQ-025 Simultaneous output and input handshake in one cycle SHALL replace the held word with no bubble (full throughput).
REQ-026 A single address counter SHALL be loaded into out_addr on each input handshake and increment modulo DEPTH on each input handshake.
REQ-027 The input handshake that uses address DEPTH-1 SHALL set mem_full; the counter wraps to 0 and no further input is accepted until flush or reset.
REQ-028 The word at address DEPTH-1 SHALL still be delivered normally while mem_full=1.
REQ-029 flush=1 SHALL, at the next edge, clear out_valid, address counter, mem_full and illegal; a pending word is discarded; in_valid in the flush cycle is ignored.
REQ-030 Output state is a two-state machine: EMPTY (out_valid=0) -> HOLD on input handshake; HOLD -> EMPTY on output handshake without input handshake; HOLD -> HOLD otherwise.

Reset
REQ-031 rst_n=0 SHALL immediately force out_valid=0, instr=0, out_addr=0, address counter=0, mem_full=0, illegal=0, state EMPTY.
REQ-032 in_ready SHALL be 0 while rst_n=0 and 1 in the first cycle after release (EMPTY, not full).
REQ-033 Reset asserted mid-transfer SHALL discard the held word; no partial output after release.

Verification
REQ-034 R: opcode 0110011, rd 3, rs1 1, rs2 2, funct3 0, funct7 0, out_ready=1 -> next cycle instr 0x002081B3, out_addr 0.
REQ-035 I: opcode 0010011, rd 5, rs1 0, funct3 0, imm 0xFFF -> instr 0xFFF00293; S: opcode 0100011, rs1 1, rs2 2, funct3 010, imm 8 -> instr 0x0020A423 at out_addr 1.
REQ-036 Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, instr/out_addr stable; on out_ready=1 next word follows back-to-back.
REQ-037 Illegal: opcode 1111111 -> instr 0x00000013, illegal=1 and held until flush, address still increments.
REQ-038 Fill: ADDR_W=2, stream 4 words with out_ready=1 -> out_addr 0..3, mem_full=1 after 4th accept, in_ready=0; flush -> mem_full=0, next word at out_addr 0.
REQ-039 Reset mid-operation: rst_n low while out_valid=1 and stalled -> out_valid=0 immediately, out_addr 0 after release.
